// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one padded 512-bit block into W[0..63],
// presenting each word with its round constant K[t] and round index, and
// stepping one word per cycle while the consumer holds adv high.
module sha256_msg_schedule #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    input  logic [511:0] blk_data,
    output logic         blk_ready,
    input  logic         adv,
    output logic [31:0]  w_out,
    output logic [31:0]  k_out,
    output logic [6:0]   round,
    output logic         w_valid,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [6:0] LastRound = 7'(ROUNDS - 1);
    localparam logic [6:0] EndRound  = 7'(ROUNDS);

    localparam logic [31:0] KRom [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_e      state_q, state_d;
    logic [31:0] window_q [16];
    logic [31:0] window_d [16];
    logic [31:0] k_q, k_d;
    logic [6:0]  round_q, round_d;
    logic [31:0] new_word;
    logic [5:0]  k_idx;

    // Next schedule word from the current 16-word window; sum wraps mod 2^32.
    always_comb begin
        new_word = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];
        k_idx    = round_q[5:0] + 6'd1;
    end

    // Next-state logic: capture in idle, shift per advance in run, one done cycle.
    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        k_d      = k_q;
        round_d  = round_q;
        case (state_q)
            StIdle: begin
                if (blk_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        window_d[i] = blk_data[511 - 32*i -: 32];
                    end
                    k_d     = KRom[0];
                    round_d = 7'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (adv) begin
                    if (round_q == LastRound) begin
                        state_d = StDone;
                        round_d = EndRound;
                    end else begin
                        for (int i = 0; i < 15; i++) begin
                            window_d[i] = window_q[i+1];
                        end
                        window_d[15] = new_word;
                        k_d          = KRom[k_idx];
                        round_d      = round_q + 7'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                round_d = 7'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            for (int i = 0; i < 16; i++) begin
                window_q[i] <= 32'd0;
            end
            k_q     <= 32'd0;
            round_q <= 7'd0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            k_q      <= k_d;
            round_q  <= round_d;
        end
    end

    assign blk_ready = (state_q == StIdle);
    assign w_valid   = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign w_out     = window_q[0];
    assign k_out     = k_q;
    assign round     = round_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a plain-arithmetic
// SHA-256 message expansion model.
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic [511:0] blk_data = '0;
    logic         blk_ready;
    logic         adv = 1'b0;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic [6:0]   round;
    logic         w_valid;
    logic         done;

    int checks = 0;
    int failures = 0;

    sha256_msg_schedule #(.ROUNDS(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_ready (blk_ready),
        .adv       (adv),
        .w_out     (w_out),
        .k_out     (k_out),
        .round     (round),
        .w_valid   (w_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [31:0] ktab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Reference schedule for the block under test.
    logic [31:0] mdl_w [64];

    // Observations recorded by play_block.
    logic [31:0] cons_w [64];
    logic [31:0] cons_k [64];
    logic [6:0]  cons_r [64];
    logic [31:0] cyc_w [300];
    logic        cyc_v [300];
    logic        cyc_adv [300];
    int          n_cons, done_at, done_cnt, stalls, bad_ready;
    logic [6:0]  post_round;
    logic        post_ready, post_done;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic model(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) mdl_w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            logic [31:0] s0, s1;
            s0 = rotr(mdl_w[t-15], 7) ^ rotr(mdl_w[t-15], 18) ^ (mdl_w[t-15] >> 3);
            s1 = rotr(mdl_w[t-2], 17) ^ rotr(mdl_w[t-2], 19) ^ (mdl_w[t-2] >> 10);
            mdl_w[t] = 32'(64'(s1) + 64'(mdl_w[t-7]) + 64'(s0) + 64'(mdl_w[t-16]));
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        blk_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Accepts blk from IDLE, then runs it to completion; stops on the cycle after done.
    task automatic play_block(input logic [511:0] blk, input bit stall, input bit keep_valid,
                              input logic [511:0] blk2);
        logic [3:0] patv;
        logic       a;
        patv = 4'b1001;
        n_cons = 0; done_at = -1; done_cnt = 0; stalls = 0; bad_ready = 0;
        post_round = 7'h7f; post_ready = 1'b0; post_done = 1'b1;
        blk_valid = 1'b1;
        blk_data = blk;
        adv = 1'b1;
        @(posedge clk); #1;
        blk_valid = keep_valid;
        blk_data = blk2;
        for (int cyc = 1; cyc < 300; cyc++) begin
            cyc_v[cyc] = w_valid;
            cyc_w[cyc] = w_out;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_at >= 0 && cyc > done_at) begin
                post_round = round;
                post_ready = blk_ready;
                post_done = done;
                break;
            end
            a = stall ? patv[(cyc - 1) % 4] : 1'b1;
            cyc_adv[cyc] = a;
            adv = a;
            if (w_valid) begin
                if (blk_ready) bad_ready++;
                if (a) begin
                    if (n_cons < 64) begin
                        cons_w[n_cons] = w_out;
                        cons_k[n_cons] = k_out;
                        cons_r[n_cons] = round;
                    end
                    n_cons++;
                end else begin
                    stalls++;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        blk_valid = 1'b1;
        blk_data = rand_block();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (blk_ready !== 1'b1 || w_valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got ready=%b valid=%b done=%b want 1 0 0",
                     blk_ready, w_valid, done);
        end
        checks++;
        if (round !== 7'd0 || w_out !== 32'd0 || k_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_values got round=%0d w=%h k=%h want 0 0 0", round, w_out, k_out);
        end
        blk_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_no_capture got valid=%b ready=%b want 0 1", w_valid, blk_ready);
        end
    endtask

    task automatic check_stream(input string name);
        int bad_w, bad_k, bad_r;
        bad_w = 0; bad_k = 0; bad_r = 0;
        for (int t = 0; t < 64; t++) begin
            if (cons_w[t] !== mdl_w[t]) bad_w++;
            if (cons_k[t] !== ktab[t]) bad_k++;
            if (cons_r[t] !== 7'(t)) bad_r++;
        end
        checks++;
        if (n_cons !== 64) begin
            failures++;
            $display("FAIL %s_count got %0d words want 64", name, n_cons);
        end
        checks++;
        if (bad_w != 0) begin
            failures++;
            $display("FAIL %s_words got %0d mismatching W (W63=%h) want 0 (W63=%h)",
                     name, bad_w, cons_w[63], mdl_w[63]);
        end
        checks++;
        if (bad_k != 0 || bad_r != 0) begin
            failures++;
            $display("FAIL %s_k_round got %0d bad K, %0d bad round want 0 0", name, bad_k, bad_r);
        end
        checks++;
        if (done_cnt != 1 || post_done !== 1'b0 || post_round !== 7'd0 || post_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_end got done_cnt=%0d done=%b round=%0d ready=%b want 1 0 0 1",
                     name, done_cnt, post_done, post_round, post_ready);
        end
    endtask

    task automatic test_abc();
        logic [511:0] blk;
        blk = {32'h61626380, 448'd0, 32'h00000018};
        model(blk);
        play_block(blk, 1'b0, 1'b0, '0);
        check_stream("abc");
        checks++;
        if (cons_w[0] !== 32'h61626380 || cons_k[0] !== 32'h428a2f98) begin
            failures++;
            $display("FAIL abc_w0k0 got %h/%h want 61626380/428a2f98", cons_w[0], cons_k[0]);
        end
        checks++;
        if (cons_w[15] !== 32'h18 || cons_w[16] !== 32'h61626380 || cons_w[17] !== 32'h000f0000)
        begin
            failures++;
            $display("FAIL abc_w15_17 got %h %h %h want 00000018 61626380 000f0000",
                     cons_w[15], cons_w[16], cons_w[17]);
        end
        checks++;
        if (cons_r[63] !== 7'd63 || cons_k[63] !== 32'hc67178f2) begin
            failures++;
            $display("FAIL abc_r63 got round=%0d k=%h want 63 c67178f2", cons_r[63], cons_k[63]);
        end
        checks++;
        if (done_at != 65) begin
            failures++;
            $display("FAIL abc_done_time got cycle %0d want 65", done_at);
        end
        checks++;
        if (bad_ready != 0) begin
            failures++;
            $display("FAIL abc_ready_in_run got %0d cycles ready want 0", bad_ready);
        end
    endtask

    task automatic test_stall();
        logic [511:0] blk;
        int held_bad;
        blk = {32'h61626380, 448'd0, 32'h00000018};
        model(blk);
        play_block(blk, 1'b1, 1'b0, '0);
        check_stream("stall");
        held_bad = 0;
        for (int c = 1; c < 298; c++) begin
            if (c < done_at && cyc_v[c] && !cyc_adv[c] && cyc_v[c+1] && cyc_w[c+1] !== cyc_w[c])
                held_bad++;
        end
        checks++;
        if (held_bad != 0) begin
            failures++;
            $display("FAIL stall_hold got %0d changed held words want 0", held_bad);
        end
        checks++;
        if (stalls == 0 || done_at != 65 + stalls) begin
            failures++;
            $display("FAIL stall_done_time got cycle %0d want %0d", done_at, 65 + stalls);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] a, b;
        a = rand_block();
        b = rand_block();
        model(a);
        play_block(a, 1'b0, 1'b1, b);
        check_stream("b2b_first");
        checks++;
        if (bad_ready != 0) begin
            failures++;
            $display("FAIL b2b_ready_in_run got %0d cycles ready want 0", bad_ready);
        end
        // play_block leaves us on the first IDLE cycle with blk_valid still high.
        @(posedge clk); #1;
        blk_valid = 1'b0;
        checks++;
        if (w_valid !== 1'b1 || w_out !== b[511:480] || k_out !== ktab[0] || round !== 7'd0)
        begin
            failures++;
            $display("FAIL b2b_second_w0 got v=%b w=%h k=%h r=%0d want 1 %h %h 0",
                     w_valid, w_out, k_out, round, b[511:480], ktab[0]);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic [511:0] blk, blk2;
        bit found, seen;
        blk = rand_block();
        blk_valid = 1'b1;
        blk_data = blk;
        adv = 1'b1;
        @(posedge clk); #1;
        blk_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (round === 7'd30) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mid_reach30 got round=%0d want 30 within 100 cycles", round);
        end
        do_reset();
        checks++;
        if (w_valid !== 1'b0 || round !== 7'd0 || blk_ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got v=%b r=%0d ready=%b done=%b want 0 0 1 0",
                     w_valid, round, blk_ready, done);
        end
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL mid_no_done got done pulse want none");
        end
        blk2 = rand_block();
        blk_valid = 1'b1;
        blk_data = blk2;
        @(posedge clk); #1;
        blk_valid = 1'b0;
        checks++;
        if (w_valid !== 1'b1 || w_out !== blk2[511:480] || k_out !== ktab[0] || round !== 7'd0)
        begin
            failures++;
            $display("FAIL mid_fresh_w0 got v=%b w=%h k=%h r=%0d want 1 %h %h 0",
                     w_valid, w_out, k_out, round, blk2[511:480], ktab[0]);
        end
        do_reset();
    endtask

    task automatic test_all_ones();
        logic [511:0] blk;
        blk = '1;
        model(blk);
        play_block(blk, 1'b0, 1'b0, '0);
        check_stream("ones");
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            logic [511:0] blk;
            blk = rand_block();
            model(blk);
            play_block(blk, n[0], 1'b0, '0);
            check_stream("rand");
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_all_ones();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
